// File: rtl/rca_nibble_serial_adder.sv
// Multi-precision adder: one shared 4-bit ripple-carry adder reused per nibble,
// LSB nibble first, with the carry chained through a register between cycles.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module ripple_carry_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .sum  (sum[i]),
      .cout (c[i+1])
    );
  end

  assign cout = c[4];
endmodule

module rca_nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] s_q;
  logic             carry_q;
  logic             cout_q;
  logic [IDXW-1:0]  idx_q;

  logic [3:0] a_nib;
  logic [3:0] b_nib;
  logic [3:0] sum_nib;
  logic       cout_nib;
  logic       last;

  assign last = (idx_q == IDXW'(NIBBLES - 1));

  // Operand nibble mux driven by the running index
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDXW'(i)) begin
        a_nib = a_q[4*i +: 4];
        b_nib = b_q[4*i +: 4];
      end
    end
  end

  ripple_carry_adder_4bit u_rca (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_q),
    .sum  (sum_nib),
    .cout (cout_nib)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_valid) state_d = RUN;
      RUN:  if (last)        state_d = DONE;
      DONE: if (done_ready)  state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            a_q     <= A;
            b_q     <= B;
            carry_q <= Cin;
            idx_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
          end
        end
        RUN: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDXW'(i)) begin
              s_q[4*i +: 4] <= sum_nib;
            end
          end
          carry_q <= cout_nib;
          // Index parks on the last nibble instead of wrapping
          if (last) begin
            cout_q <= cout_nib;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign start_ready = (state_q == IDLE);
  assign done_valid  = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign S           = s_q;
  assign Cout        = cout_q;

endmodule

// File: tb/tb_rca_nibble_serial_adder.sv
// Scoreboard bench for rca_nibble_serial_adder at WIDTH=16.
// Driver acts just after rising edges; monitor samples on falling edges.

module tb_rca_nibble_serial_adder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        Cin = 1'b0;
  logic [15:0] S;
  logic        Cout;
  logic        done_valid;
  logic        done_ready = 1'b1;
  logic        busy;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  typedef struct {
    logic [16:0] exp;
    int          acc;
  } exp_t;

  exp_t q[$];

  rca_nibble_serial_adder #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .A           (A),
    .B           (B),
    .Cin         (Cin),
    .S           (S),
    .Cout        (Cout),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic [16:0] exp,
                       input bit track);
    int n;
    exp_t e;
    A = a;
    B = b;
    Cin = cin;
    start_valid = 1'b1;
    n = 0;
    while (!start_ready && n < 50) begin
      step();
      n++;
    end
    if (!start_ready) chk("accept_timeout", 32'(start_ready), 32'd1);
    step();
    start_valid = 1'b0;
    if (track) begin
      e.exp = exp;
      e.acc = cyc;
      q.push_back(e);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done_valid && n < 50) begin
      step();
      n++;
    end
    if (!done_valid) chk("done_timeout", 32'(done_valid), 32'd1);
  endtask

  // Monitor: latency on rising done_valid, result on each handshake
  logic prev_dv = 1'b0;
  always @(negedge clk) begin
    if (done_valid && !prev_dv) begin
      chk("done_expected", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) chk("latency", 32'(cyc - q[0].acc), 32'd4);
    end
    if (done_valid && done_ready && q.size() > 0) begin
      chk("result", {15'd0, Cout, S}, {15'd0, q[0].exp});
      void'(q.pop_front());
    end
    prev_dv <= done_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    // 1. reset
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_S", 32'(S), 32'h0);
    chk("rst_Cout", 32'(Cout), 32'h0);
    chk("rst_done_valid", 32'(done_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_start_ready", 32'(start_ready), 32'h1);

    // 2. basic add, single-cycle done pulse
    do_op(16'h1234, 16'h4321, 1'b0, 17'h05555, 1'b1);
    chk("run_busy", 32'(busy), 32'h1);
    chk("run_start_ready", 32'(start_ready), 32'h0);
    wait_done();
    step();
    chk("dv_one_cycle", 32'(done_valid), 32'h0);

    // 3. full carry propagation
    do_op(16'hFFFF, 16'h0001, 1'b0, 17'h10000, 1'b1);
    wait_done();
    step();
    do_op(16'hFFFF, 16'h0000, 1'b1, 17'h10000, 1'b1);
    wait_done();
    step();
    do_op(16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF, 1'b1);
    wait_done();
    step();
    do_op(16'h7FFF, 16'h0001, 1'b0, 17'h08000, 1'b1);
    wait_done();
    step();

    // 4. inputs toggled during RUN must not matter
    do_op(16'h8000, 16'h8000, 1'b1, 17'h10001, 1'b1);
    n = 0;
    while (!done_valid && n < 50) begin
      A = 16'($urandom);
      B = 16'($urandom);
      Cin = 1'($urandom);
      start_valid = 1'($urandom);
      step();
      n++;
    end
    start_valid = 1'b0;
    chk("toggle_done", 32'(done_valid), 32'h1);
    step();

    // 5. backpressure in DONE with a pending start
    done_ready = 1'b0;
    do_op(16'h00FF, 16'h0F01, 1'b0, 17'h01000, 1'b1);
    wait_done();
    A = 16'h0003;
    B = 16'h0004;
    Cin = 1'b1;
    start_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_done_valid", 32'(done_valid), 32'h1);
      chk("bp_hold", {15'd0, Cout, S}, 32'h01000);
      chk("bp_start_ready", 32'(start_ready), 32'h0);
      step();
    end
    done_ready = 1'b1;
    step();
    chk("bp_idle_ready", 32'(start_ready), 32'h1);
    chk("bp_idle_dv", 32'(done_valid), 32'h0);
    begin
      exp_t e;
      step();
      start_valid = 1'b0;
      chk("bp_accepted", 32'(busy), 32'h1);
      e.exp = 17'h00008;
      e.acc = cyc;
      q.push_back(e);
    end
    wait_done();
    step();

    // 6. reset during the second RUN cycle aborts the operation
    do_op(16'hAAAA, 16'h5555, 1'b0, 17'h0FFFF, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_ready", 32'(start_ready), 32'h1);
    chk("abort_S", 32'(S), 32'h0);
    chk("abort_Cout", 32'(Cout), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    for (int i = 0; i < 6; i++) step();
    do_op(16'h0001, 16'h0001, 1'b0, 17'h00002, 1'b1);
    wait_done();
    step();

    n = 0;
    while (q.size() > 0 && n < 50) begin
      step();
      n++;
    end
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
